// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_memory_bank_if.sv
// Request/response bundle between the MEM stage and the data memory.
interface data_memory_bank_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  mem_read;
  logic                  mem_write;
  logic [1:0]            mem_size;
  logic                  mem_unsigned;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           write_data;
  logic [31:0]           read_data;
  logic                  read_valid;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  init_busy;

  modport master (
    output mem_read, mem_write, mem_size, mem_unsigned, mem_address, write_data,
    input  read_data, read_valid, misaligned, out_of_range, init_busy
  );

  modport slave (
    input  mem_read, mem_write, mem_size, mem_unsigned, mem_address, write_data,
    output read_data, read_valid, misaligned, out_of_range, init_busy
  );
endinterface

// File: rtl/dmem_align.sv
// Lane steering for sub-word accesses: byte enables, replicated store data,
// extended load data and alignment check.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    o_be         = '0;
    o_wword      = '0;
    o_rdata      = '0;
    o_misaligned = 1'b0;
    case (size_e'(i_size))
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_lane;
        o_wword = {4{i_wdata[7:0]}};
        o_rdata = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_misaligned = i_lane[0];
        o_be         = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wword      = {2{i_wdata[15:0]}};
        o_rdata      = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      SZ_WORD: begin
        o_misaligned = |i_lane;
        o_be         = '1;
        o_wword      = i_wdata;
        o_rdata      = i_rword;
      end
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_bank.sv
// Byte-addressed data memory with registered loads, error strobes and a
// hardware clear sequence after every reset.
module data_memory_bank
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  data_memory_bank_if.slave bus
);

  localparam int unsigned IDX_W = clog2(DEPTH);

  state_e r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;

  logic [31:0] r_mem [DEPTH];

  logic [31:0] r_read_data;
  logic        r_read_valid;
  logic        r_misaligned;
  logic        r_out_of_range;

  logic [ADDR_WIDTH-3:0] w_word_idx;
  logic [IDX_W-1:0]      w_idx;
  logic [31:0]           w_rword;
  logic [3:0]            w_be;
  logic [31:0]           w_wword;
  logic [31:0]           w_rdata;
  logic                  w_mis;
  logic                  w_oor;
  logic                  w_req;
  logic                  w_accept;
  logic                  w_store;
  logic                  w_fill_we;

  assign w_word_idx = bus.mem_address[ADDR_WIDTH-1:2];
  assign w_idx      = w_word_idx[IDX_W-1:0];
  assign w_oor      = (64'(w_word_idx) >= 64'(DEPTH));
  // Asynchronous array read gives pre-store contents on a same-edge read/write.
  assign w_rword    = r_mem[w_idx];

  dmem_align u_align (
    .i_size       (bus.mem_size),
    .i_lane       (bus.mem_address[1:0]),
    .i_unsigned   (bus.mem_unsigned),
    .i_wdata      (bus.write_data),
    .i_rword      (w_rword),
    .o_be         (w_be),
    .o_wword      (w_wword),
    .o_rdata      (w_rdata),
    .o_misaligned (w_mis)
  );

  assign w_req     = (r_state == ST_READY) && (bus.mem_read || bus.mem_write);
  assign w_accept  = w_req && !w_mis && !w_oor;
  assign w_store   = reset && w_accept && bus.mem_write;
  assign w_fill_we = reset && (r_state == ST_INIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == ST_INIT) begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (r_cnt == IDX_W'(DEPTH - 1)) begin
        w_state_nxt = ST_READY;
        w_cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_mem[r_cnt] <= INIT_VALUE;
    end else if (w_store) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
        end
      end
    end
  end

  // Misalignment outranks range; rejected accesses leave read_data alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_read_data    <= '0;
      r_read_valid   <= 1'b0;
      r_misaligned   <= 1'b0;
      r_out_of_range <= 1'b0;
    end else begin
      r_read_valid   <= 1'b0;
      r_misaligned   <= 1'b0;
      r_out_of_range <= 1'b0;
      if (w_req) begin
        if (w_mis) begin
          r_misaligned <= 1'b1;
        end else if (w_oor) begin
          r_out_of_range <= 1'b1;
        end else if (bus.mem_read) begin
          r_read_data  <= w_rdata;
          r_read_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.read_data    = r_read_data;
  assign bus.read_valid   = r_read_valid;
  assign bus.misaligned   = r_misaligned;
  assign bus.out_of_range = r_out_of_range;
  assign bus.init_busy    = (r_state == ST_INIT);

endmodule

// File: tb/tb_data_memory_bank.sv
// Scoreboard bench for data_memory_bank against a byte-array reference model.
module tb_data_memory_bank;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] INIT  = 32'hDEAD_BEEF;
  localparam int K_RD  = 0;
  localparam int K_MIS = 1;
  localparam int K_OOR = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_memory_bank_if #(.ADDR_WIDTH(32)) bus ();

  data_memory_bank #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (32),
    .INIT_VALUE (INIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  logic [7:0]  mbytes [DEPTH*4];
  logic [31:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH*4; i++) mbytes[i] = 8'(INIT >> (8*(i%4)));
    last_rd = '0;
  endtask

  // Reference behaviour: byte-addressed array, size in bytes, plain arithmetic.
  task automatic model_access(input bit rd, input bit wr, input logic [1:0] sz,
                              input bit uns, input logic [31:0] addr, input logic [31:0] wd);
    int nb;
    logic [63:0] v;
    exp_t e;
    if (!rd && !wr) return;
    case (sz)
      2'd0:    nb = 1;
      2'd1:    nb = 2;
      2'd2:    nb = 4;
      default: nb = 0;
    endcase
    if (nb == 0 || (addr % nb) != 0) begin
      e.kind = K_MIS; e.data = last_rd; q.push_back(e);
    end else if ((addr >> 2) >= DEPTH) begin
      e.kind = K_OOR; e.data = last_rd; q.push_back(e);
    end else begin
      if (rd) begin
        v = '0;
        for (int k = 0; k < nb; k++) v = v | (64'(mbytes[int'(addr) + k]) << (8*k));
        if (!uns && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
        last_rd = v[31:0];
        e.kind = K_RD; e.data = last_rd; q.push_back(e);
      end
      if (wr) begin
        for (int k = 0; k < nb; k++) mbytes[int'(addr) + k] = 8'(wd >> (8*k));
      end
    end
  endtask

  task automatic clear_req();
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_size     = 2'd0;
    bus.mem_unsigned = 1'b0;
    bus.mem_address  = '0;
    bus.write_data   = '0;
  endtask

  task automatic acc(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.mem_read     = rd;
    bus.mem_write    = wr;
    bus.mem_size     = sz;
    bus.mem_unsigned = uns;
    bus.mem_address  = addr;
    bus.write_data   = wd;
    model_access(rd, wr, sz, uns, addr, wd);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    clear_req();
    repeat (n) @(negedge clk);
  endtask

  // Caller is at a negedge (or time 0); a request pulse is issued mid-fill.
  task automatic do_reset(input int hold);
    int cnt;
    reset = 1'b0;
    clear_req();
    repeat (hold) @(negedge clk);
    check("rst_read_data",    bus.read_data,           32'h0);
    check("rst_read_valid",   32'(bus.read_valid),     32'h0);
    check("rst_misaligned",   32'(bus.misaligned),     32'h0);
    check("rst_out_of_range", 32'(bus.out_of_range),   32'h0);
    check("rst_init_busy",    32'(bus.init_busy),      32'h1);
    model_reset();
    reset = 1'b1;
    cnt = 0;
    while (bus.init_busy && cnt < 64) begin
      cnt++;
      if (cnt == 4) begin
        bus.mem_read    = 1'b1;
        bus.mem_write   = 1'b1;
        bus.mem_size    = 2'd2;
        bus.mem_address = 32'h0;
        bus.write_data  = 32'h0BAD_F00D;
      end else if (cnt == 5) begin
        clear_req();
      end
      @(negedge clk);
    end
    clear_req();
    check("init_busy_cycles", 32'(cnt), 32'(DEPTH));
  endtask

  always @(posedge clk) begin
    int kind;
    int n;
    exp_t e;
    #1;
    n = int'(bus.read_valid) + int'(bus.misaligned) + int'(bus.out_of_range);
    if (n > 0) begin
      if (n > 1) begin
        total++; bad++;
        $display("FAIL strobe_overlap: got rv=%b mis=%b oor=%b expected one strobe",
                 bus.read_valid, bus.misaligned, bus.out_of_range);
      end
      kind = bus.read_valid ? K_RD : (bus.misaligned ? K_MIS : K_OOR);
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe: got kind %0d data %h expected no strobe at %0t",
                 kind, bus.read_data, $time);
      end else begin
        e = q.pop_front();
        check("strobe_kind", 32'(kind), 32'(e.kind));
        check("read_data",   bus.read_data, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    clear_req();
    do_reset(3);

    acc(1, 0, 2'd2, 0, 32'h00, 32'h0);
    acc(1, 0, 2'd2, 0, 32'h3C, 32'h0);

    acc(0, 1, 2'd2, 0, 32'h08, 32'h1234_5678);
    acc(0, 1, 2'd0, 0, 32'h09, 32'h0000_00AA);
    acc(1, 0, 2'd2, 0, 32'h08, 32'h0);
    acc(1, 0, 2'd0, 0, 32'h09, 32'h0);
    acc(1, 0, 2'd0, 1, 32'h09, 32'h0);

    acc(0, 1, 2'd1, 0, 32'h12, 32'h0000_8001);
    acc(1, 0, 2'd1, 0, 32'h12, 32'h0);
    acc(1, 0, 2'd1, 1, 32'h12, 32'h0);
    acc(1, 0, 2'd1, 0, 32'h11, 32'h0);
    idle(1);

    acc(1, 0, 2'd2, 0, 32'h40, 32'h0);
    acc(1, 0, 2'd2, 0, 32'h41, 32'h0);
    acc(1, 0, 2'd3, 0, 32'h0C, 32'h0);

    acc(0, 1, 2'd2, 0, 32'h04, 32'h0000_0000);
    acc(1, 1, 2'd2, 0, 32'h04, 32'h5555_5555);
    acc(1, 0, 2'd2, 0, 32'h04, 32'h0);
    idle(2);

    for (int i = 0; i < 300; i++) begin
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom_range(0, 32'h47);
      acc(1'($urandom), 1'($urandom), sz, 1'($urandom), addr, $urandom);
    end
    idle(2);

    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (7) @(negedge clk);
    do_reset(2);

    for (int w = 0; w < int'(DEPTH); w++) acc(1, 0, 2'd2, 0, 32'(w * 4), 32'h0);
    idle(3);

    check("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_bank.md
Name: data_memory_bank

Overview:
Parametrised, byte-addressed data memory for the MEM stage of the pipelined processor. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. Reads have a registered one-cycle latency and a valid strobe. After every reset a hardware fill sequence clears the array, and the block flags misaligned and out-of-range accesses instead of corrupting memory.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, minimum 4.
ADDR_WIDTH, 32, width of the byte address from the ALU.
INIT_VALUE, 32'h0000_0000, word written to every location during the reset fill.

Ports:
clk  in  1  system clock; all state changes on posedge.
reset  in  1  synchronous, active-low reset; sampled on posedge clk.
mem_read  in  1  load request this cycle.
mem_write  in  1  store request this cycle.
mem_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads.
mem_address  in  ADDR_WIDTH  byte address.
write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
read_data  out  32  extended load result.
read_valid  out  1  one-cycle strobe: read_data is new.
misaligned  out  1  one-cycle strobe: access rejected for alignment or reserved size.
out_of_range  out  1  one-cycle strobe: access rejected, word index >= DEPTH.
init_busy  out  1  high while the reset fill runs; requests are ignored.

Behaviour:
- Reset (reset==0 at posedge):
  - read_data=0, read_valid=0, misaligned=0, out_of_range=0, init_busy=1.
  - Fill counter=0; state=INIT.
  - Holds for as long as reset stays low.
  - Reset mid-fill or mid-operation restarts the fill from word 0.
- INIT state:
  - Each cycle with reset==1 writes INIT_VALUE to word[cnt], then cnt++.
  - After word DEPTH-1 is written, go to READY; init_busy falls on the same edge.
  - Fill takes exactly DEPTH cycles after reset release.
  - mem_read/mem_write are ignored in INIT: no strobes, no writes, read_data holds.
- READY state:
  - Word index = mem_address[ADDR_WIDTH-1:2]; lane = mem_address[1:0].
- Error checks, in priority order:
  - Reserved size, half with addr[0]=1, or word with addr[1:0]!=0 -> misaligned=1 next cycle.
  - Otherwise index >= DEPTH -> out_of_range=1 next cycle.
  - A rejected access performs no write, gives no read_valid, and leaves read_data unchanged.
  - If both errors apply, only misaligned is asserted.
- Store (posedge):
  - Byte writes lane addr[1:0] with write_data[7:0].
  - Half writes lanes {addr[1],0} and {addr[1],1} with write_data[15:0], little-endian.
  - Word writes all four lanes.
  - Other lanes are preserved.
- Load:
  - Request sampled at edge N; at edge N read_data <= extended lane data and read_valid <= 1.
  - Both outputs are visible throughout cycle N+1; latency is 1.
  - read_valid is high for one cycle only unless a load is issued every cycle.
  - read_data holds its last value otherwise.
- Extension:
  - Byte: mem_unsigned ? {24'b0,b} : {{24{b[7]}},b}.
  - Half: the same rule at 16 bits.
  - Word: passed through unmodified.
- Simultaneous mem_read and mem_write on the same address: read-before-write. The load returns pre-store contents; the store completes on the same edge.
- Strobes are registered, never combinational from the inputs.

Decomposition:
- Package dmem_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - State encoding ST_INIT, ST_READY.
  - Function clog2 for the fill counter and index width.
- Sub-module dmem_align (combinational):
  - From size, lane, mem_unsigned, write_data and the raw read word, produce byte enables, the replicated store word, the extended load value and the misaligned flag.
- Top level holds the array, the fill FSM/counter and the output registers.

Test Plan:
- DEPTH=16, INIT_VALUE=32'hDEAD_BEEF; hold reset low 3 cycles, release -> init_busy high exactly 16 cycles; then word loads of addr 0x00 and 0x3C return 32'hDEAD_BEEF; a store during INIT has no effect.
- Word store 32'h1234_5678 @0x08; byte store 8'hAA @0x09 -> word load @0x08 = 32'h1234_AA78; signed byte load @0x09 = 32'hFFFF_FFAA; unsigned = 32'h0000_00AA.
- Half store 16'h8001 @0x12 -> signed half load @0x12 = 32'hFFFF_8001, unsigned = 32'h0000_8001; half load @0x11 -> misaligned pulse, no read_valid.
- Word load @0x40 (index 16) -> out_of_range pulse, read_data unchanged; word load @0x41 -> misaligned only.
- Same cycle: mem_read=1, mem_write=1 @0x04, old=32'h0, new=32'h5555_5555 -> read_data=32'h0; next load returns 32'h5555_5555.
- Reset asserted at fill count 7 -> fill restarts; init_busy stays high 16 cycles after release; all words equal INIT_VALUE.
